// File: rtl/camera_pkg.sv
// Shared types and constants for the camera capture path: FSM state encoding,
// default frame geometry and RGB565 field boundaries.
package camera_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam int unsigned DEF_H_RES = 320;
   localparam int unsigned DEF_V_RES = 240;

   localparam int unsigned RGB_R_MSB = 15;
   localparam int unsigned RGB_R_LSB = 11;
   localparam int unsigned RGB_G_MSB = 10;
   localparam int unsigned RGB_G_LSB = 5;
   localparam int unsigned RGB_B_MSB = 4;
   localparam int unsigned RGB_B_LSB = 0;

endpackage

// File: rtl/rgb565_to_gray.sv
// RGB565 to 8-bit luma, Y = (77*R + 150*G + 29*B) >> 8 on 8-bit expanded channels.
// Output is registered and updates only when in_valid is high.
module rgb565_to_gray
   import camera_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [15:0] rgb,
   output logic [7:0]  gray
);

   logic [4:0]  r5;
   logic [5:0]  g6;
   logic [4:0]  b5;
   logic [7:0]  r8;
   logic [7:0]  g8;
   logic [7:0]  b8;
   logic [15:0] sum;

   // Channels are widened by replicating their MSBs so full scale maps to 8'hFF.
   always_comb begin
      r5  = rgb[RGB_R_MSB:RGB_R_LSB];
      g6  = rgb[RGB_G_MSB:RGB_G_LSB];
      b5  = rgb[RGB_B_MSB:RGB_B_LSB];
      r8  = {r5, r5[4:2]};
      g8  = {g6, g6[5:4]};
      b8  = {b5, b5[4:2]};
      sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gray <= '0;
      end else if (in_valid) begin
         gray <= sum[15:8];
      end
   end

endmodule

// File: rtl/camera_frame_writer.sv
// Assembles RGB565 camera bytes into pixels and writes them to a frame buffer.
// Define CAMERA_GRAYSCALE_EN to store 8-bit luma instead of raw RGB565.
module camera_frame_writer
   import camera_pkg::*;
#(
   parameter int unsigned H_RES  = DEF_H_RES,
   parameter int unsigned V_RES  = DEF_V_RES,
   parameter int unsigned ADDR_W = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture_enable,
   input  logic              href,
   input  logic [7:0]        cam_data,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [15:0]       wdata,
   output logic              frame_done,
   output logic              frame_ok,
   output logic              busy
);

   localparam int unsigned X_W = $clog2(H_RES + 1);
   localparam int unsigned Y_W = $clog2(V_RES + 1);
   localparam logic [X_W-1:0]    X_LIM     = X_W'(H_RES);
   localparam logic [Y_W-1:0]    Y_LIM     = Y_W'(V_RES);
   localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(H_RES * V_RES);

   state_t            state;
   logic              cap_prev;
   logic              href_prev;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [ADDR_W-1:0] addr;
   logic              phase;
   logic [7:0]        hi;
   logic              pix_we;
   logic [ADDR_W-1:0] pix_addr;
   logic [15:0]       pix_data;
   logic              cap_rise;
   logic              cap_fall;

   assign cap_rise = capture_enable & ~cap_prev;
   assign cap_fall = ~capture_enable & cap_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cap_prev   <= 1'b0;
         href_prev  <= 1'b0;
         x          <= '0;
         y          <= '0;
         addr       <= '0;
         phase      <= 1'b0;
         hi         <= '0;
         pix_we     <= 1'b0;
         pix_addr   <= '0;
         pix_data   <= '0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         cap_prev   <= capture_enable;
         href_prev  <= href;
         pix_we     <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cap_rise) begin
                  state <= ST_ACTIVE;
                  busy  <= 1'b1;
                  x     <= '0;
                  y     <= '0;
                  addr  <= '0;
                  phase <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (href) begin
                  phase <= ~phase;
                  if (!phase) begin
                     hi <= cam_data;
                  end else if (x < X_LIM && y < Y_LIM) begin
                     pix_we   <= 1'b1;
                     pix_addr <= addr;
                     pix_data <= {hi, cam_data};
                     addr     <= addr + 1'b1;
                     x        <= x + 1'b1;
                  end
               end else if (href_prev) begin
                  x     <= '0;
                  phase <= 1'b0;
                  if (y < Y_LIM) begin
                     y <= y + 1'b1;
                  end
               end
               // Pixel handling above still applies in the cycle the window closes.
               if (cap_fall) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
               end
            end
            ST_DONE: begin
               frame_done <= 1'b1;
               frame_ok   <= (addr == FRAME_PIX);
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CAMERA_GRAYSCALE_EN
   logic              gray_we;
   logic [ADDR_W-1:0] gray_addr;
   logic [7:0]        gray_y;

   rgb565_to_gray u_gray (
      .clk      (clk),
      .reset    (reset),
      .in_valid (pix_we),
      .rgb      (pix_data),
      .gray     (gray_y)
   );

   // Address and strobe are delayed to line up with the registered luma.
   always_ff @(posedge clk) begin
      if (reset) begin
         gray_we   <= 1'b0;
         gray_addr <= '0;
      end else begin
         gray_we <= pix_we;
         if (pix_we) begin
            gray_addr <= pix_addr;
         end
      end
   end

   assign we    = gray_we;
   assign waddr = gray_addr;
   assign wdata = {8'h00, gray_y};
`else
   assign we    = pix_we;
   assign waddr = pix_addr;
   assign wdata = pix_data;
`endif

endmodule

// File: tb/tb_camera_frame_writer.sv
// Scoreboard bench for camera_frame_writer on a reduced 8x4 frame.
module tb_camera_frame_writer;

   localparam int H = 8;
   localparam int V = 4;
   localparam int AW = 17;
`ifdef CAMERA_GRAYSCALE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          capture_enable = 1'b0;
   logic          href = 1'b0;
   logic [7:0]    cam_data = '0;
   logic          we;
   logic [AW-1:0] waddr;
   logic [15:0]   wdata;
   logic          frame_done;
   logic          frame_ok;
   logic          busy;

   camera_frame_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .capture_enable (capture_enable),
      .href           (href),
      .cam_data       (cam_data),
      .we             (we),
      .waddr          (waddr),
      .wdata          (wdata),
      .frame_done     (frame_done),
      .frame_ok       (frame_ok),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          addr;
      logic [15:0] data;
      int          cyc;
   } wr_t;

   wr_t wq[$];
   bit  dq[$];
   int  checks = 0;
   int  errors = 0;
   int  last_waddr = -1;

   bit m_active = 0;
   int m_x = 0;
   int m_y = 0;
   int m_addr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] expect_data(input logic [15:0] p);
`ifdef CAMERA_GRAYSCALE_EN
      logic [7:0] r8;
      logic [7:0] g8;
      logic [7:0] b8;
      int s;
      r8 = {p[15:11], p[15:13]};
      g8 = {p[10:5], p[10:9]};
      b8 = {p[4:0], p[4:2]};
      s  = 77 * int'(r8) + 150 * int'(g8) + 29 * int'(b8);
      return {8'h00, 8'(s >> 8)};
`else
      return p;
`endif
   endfunction

   function automatic logic [15:0] pix_val(input int line, input int p);
      return {8'(line * 16 + p + 1), 8'(p * 37 + line * 5)};
   endfunction

   wr_t mon_e;
   always @(negedge clk) begin
      if (!reset) begin
         if (we) begin
            if (wq.size() == 0) begin
               chk("unexpected_write", {15'd0, waddr}, 32'hFFFF_FFFF);
            end else begin
               mon_e = wq.pop_front();
               chk("waddr", {15'd0, waddr}, mon_e.addr);
               chk("wdata", {16'd0, wdata}, {16'd0, mon_e.data});
               chk("we_cycle", cyc, mon_e.cyc);
               last_waddr = int'(waddr);
            end
         end
         if (frame_done) begin
            if (dq.size() == 0) begin
               chk("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
               chk("frame_ok_at_done", {31'd0, frame_ok}, {31'd0, dq.pop_front()});
            end
         end
      end
   end

   task automatic tick(input logic h, input logic [7:0] d);
      @(posedge clk);
      #1;
      href = h;
      cam_data = d;
   endtask

   task automatic send_pixel(input logic [15:0] pv, input bit drop_ce);
      tick(1'b1, pv[15:8]);
      @(posedge clk);
      #1;
      href = 1'b1;
      cam_data = pv[7:0];
      if (drop_ce) capture_enable = 1'b0;
      if (m_active && m_x < H && m_y < V) begin
         wq.push_back('{m_addr, expect_data(pv), cyc + LAT});
         m_addr++;
         m_x++;
      end
      if (drop_ce && m_active) begin
         dq.push_back(m_addr == H * V);
         m_active = 0;
      end
   endtask

   task automatic send_line(input int line, input int npix, input bit odd);
      for (int p = 0; p < npix; p++) send_pixel(pix_val(line, p), 1'b0);
      if (odd) tick(1'b1, 8'h5A);
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      if (m_active) begin
         m_x = 0;
         if (m_y < V) m_y++;
      end
   endtask

   task automatic start_frame();
      @(posedge clk);
      #1;
      capture_enable = 1'b1;
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      m_active = 1;
      m_x = 0;
      m_y = 0;
      m_addr = 0;
      chk("busy_active", {31'd0, busy}, 32'd1);
   endtask

   task automatic settle_frame(input bit exp_ok);
      repeat (4) tick(1'b0, 8'h00);
      chk("busy_after_frame", {31'd0, busy}, 32'd0);
      chk("pending_writes", wq.size(), 32'd0);
      chk("pending_done", dq.size(), 32'd0);
      chk("frame_ok_held", {31'd0, frame_ok}, {31'd0, exp_ok});
   endtask

   task automatic end_frame(input bit exp_ok);
      @(posedge clk);
      #1;
      capture_enable = 1'b0;
      dq.push_back(m_addr == H * V);
      m_active = 0;
      settle_frame(exp_ok);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_we", {31'd0, we}, 32'd0);
      chk("reset_waddr", {15'd0, waddr}, 32'd0);
      chk("reset_wdata", {16'd0, wdata}, 32'd0);
      chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
      chk("reset_frame_ok", {31'd0, frame_ok}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      tick(1'b0, 8'h00);

      // href activity with the capture window closed
      send_line(0, 8, 1'b0);
      send_line(1, 3, 1'b1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_no_writes", wq.size(), 32'd0);

      // complete frame
      start_frame();
      for (int l = 0; l < V; l++) send_line(l, H, 1'b0);
      end_frame(1'b1);
      chk("full_last_waddr", last_waddr, 32'd31);

      // overlong line, then a line ending with a dangling byte
      start_frame();
      send_line(10, H + 1, 1'b0);
      send_line(11, H, 1'b1);
      send_line(12, H, 1'b0);
      send_line(13, H, 1'b0);
      end_frame(1'b1);

      // short frame
      start_frame();
      for (int l = 0; l < V - 1; l++) send_line(20 + l, H, 1'b0);
      end_frame(1'b0);
      chk("short_last_waddr", last_waddr, 32'd23);

      // extra line beyond V_RES is dropped
      start_frame();
      for (int l = 0; l < V + 1; l++) send_line(30 + l, H, 1'b0);
      end_frame(1'b1);
      chk("tall_last_waddr", last_waddr, 32'd31);

      // window closes on the same cycle the final pixel completes
      start_frame();
      for (int l = 0; l < V - 1; l++) send_line(40 + l, H, 1'b0);
      for (int p = 0; p < H - 1; p++) send_pixel(pix_val(43, p), 1'b0);
      send_pixel(16'hFFFF, 1'b1);
      settle_frame(1'b1);
      chk("close_last_waddr", last_waddr, 32'd31);

      // reset mid-frame, then a fresh frame
      start_frame();
      send_pixel(16'h0000, 1'b0);
      send_line(50, H - 1, 1'b0);
      send_pixel(pix_val(51, 0), 1'b0);
      send_pixel(pix_val(51, 1), 1'b0);
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b1;
      capture_enable = 1'b0;
      m_active = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("midreset_we", {31'd0, we}, 32'd0);
      chk("midreset_waddr", {15'd0, waddr}, 32'd0);
      chk("midreset_frame_ok", {31'd0, frame_ok}, 32'd0);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      repeat (3) tick(1'b0, 8'h00);
      chk("midreset_no_done", dq.size(), 32'd0);
      start_frame();
      send_line(60, H, 1'b0);
      end_frame(1'b0);
      chk("fresh_last_waddr", last_waddr, 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/camera_frame_writer.md
CAMERA_FRAME_WRITER -- requirements
Module: camera_frame_writer

Interface
REQ-001 SHALL have parameter H_RES, default 320, active pixels per line.
REQ-002 SHALL have parameter V_RES, default 240, active lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, frame-buffer address width.
REQ-004 SHALL have port clk  input  1  camera pixel clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port capture_enable  input  1  frame window from capture controller; rises and falls only at vsync falling edges.
REQ-007 SHALL have port href  input  1  camera line-valid.
REQ-008 SHALL have port cam_data  input  8  camera byte bus, RGB565, high byte first.
REQ-009 SHALL have port we  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-010 SHALL have port waddr  output  ADDR_W  write address, y*H_RES+x.
REQ-011 SHALL have port wdata  output  16  pixel data.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of captured frame.
REQ-013 SHALL have port frame_ok  output  1  high when the last frame wrote exactly H_RES*V_RES pixels; held until next frame_done.
REQ-014 SHALL have port busy  output  1  high in ACTIVE state.

Function
REQ-015 SHALL implement FSM IDLE -> ACTIVE -> DONE -> IDLE.
REQ-016 IDLE: on capture_enable rising edge (registered previous value 0, current 1) SHALL enter ACTIVE and clear x, y, addr and byte phase.
REQ-017 ACTIVE: each href-high cycle SHALL toggle byte phase; phase 0 latches cam_data as high byte, phase 1 completes a pixel.
REQ-018 On pixel completion with x<H_RES and y<V_RES, SHALL assert we with waddr=addr and wdata={hi,lo} exactly 1 cycle after the second byte is sampled; then x and addr increment.
REQ-019 Pixels with x>=H_RES or y>=V_RES SHALL be dropped (no we, addr unchanged).
REQ-020 On href falling edge SHALL clear x and byte phase and increment y (saturating at V_RES); a dangling odd byte is discarded.
REQ-021 ACTIVE: on capture_enable falling edge SHALL enter DONE; a pixel completing in that same cycle is still written.
REQ-022 DONE: SHALL pulse frame_done for one cycle, set frame_ok = (addr == H_RES*V_RES), return to IDLE next cycle.
REQ-023 href activity in IDLE or DONE SHALL produce no writes.
REQ-024 we, frame_done SHALL be single-cycle pulses; waddr, wdata hold their last value when we=0.

Reset
REQ-025 On reset: state=IDLE, we=0, waddr=0, wdata=0, frame_done=0, frame_ok=0, busy=0, all counters 0, capture_enable edge register 0.
REQ-026 Reset asserted mid-frame SHALL abort without frame_done; a subsequent capture_enable rise starts a fresh frame at address 0.

Configuration
REQ-027 Macro CAMERA_GRAYSCALE_EN: when defined, wdata={8'h00, Y}, Y=(77*R8+150*G8+29*B8)>>8 with R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}; one extra pipeline register, we latency becomes 2 cycles after second byte.
REQ-028 Without CAMERA_GRAYSCALE_EN: wdata is raw RGB565, latency 1 cycle, no multiplier logic present.

Structure
REQ-029 Shared package camera_pkg SHALL hold the FSM state enum, default H_RES/V_RES, and the RGB565 field-slice constants.
REQ-030 Grayscale conversion SHALL be a sub-module rgb565_to_gray (registered output), instantiated only under CAMERA_GRAYSCALE_EN.

Verification
REQ-031 Full 320x240 frame of incrementing pixels (hi=addr[15:8], lo=addr[7:0]) -> 76800 writes, last waddr=76799, frame_done once, frame_ok=1.
REQ-032 Line with 321 pixels -> 320 writes, 321st dropped, next line starts at waddr=320*(y+1).
REQ-033 Frame with 239 lines -> frame_done pulse, frame_ok=0, last waddr=76479.
REQ-034 href toggling while capture_enable=0 -> zero writes, busy=0.
REQ-035 reset asserted at pixel 1000 -> no frame_done; next frame first write waddr=0.
REQ-036 CAMERA_GRAYSCALE_EN, pixel 16'hFFFF -> wdata=16'h00FF; 16'h0000 -> 16'h0000; we 2 cycles after second byte.
